// File: rtl/ternary_serial_subtractor_pkg.sv
// ternary_serial_subtractor_pkg: balanced-ternary trit type, constants, helpers and subtractor FSM states.
package ternary_pkg;
  typedef logic signed [1:0] trit_t;
  localparam trit_t T_NEG = 2'sb11;
  localparam trit_t T_ZERO = 2'sb00;
  localparam trit_t T_POS = 2'sb01;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} tsub_state_e;
  function automatic trit_t trit_neg(trit_t t);
    return t == T_POS ? T_NEG : t == T_NEG ? T_POS : T_ZERO;
  endfunction
  function automatic int trit_val(trit_t t);
    return t == T_POS ? 1 : t == T_NEG ? -1 : 0;
  endfunction
  function automatic trit_t trit_of(int v);
    return v > 0 ? T_POS : v < 0 ? T_NEG : T_ZERO;
  endfunction
endpackage

// File: rtl/ternary_serial_subtractor_if.sv
// ternary_serial_subtractor_if: operand/result handshake bundle for the serial subtractor.
interface ternary_serial_subtractor_if import ternary_pkg::*; #(parameter int WIDTH = 27);
  logic in_valid, in_ready, out_valid, out_ready, is_zero, is_neg;
  trit_t [WIDTH-1:0] a, b, diff;
  trit_t bin, bout;
  modport master (output in_valid, a, b, bin, out_ready,
                  input in_ready, out_valid, diff, bout, is_zero, is_neg);
  modport slave (input in_valid, a, b, bin, out_ready,
                 output in_ready, out_valid, diff, bout, is_zero, is_neg);
endinterface

// File: rtl/ternary_adder.sv
// ternary_adder: combinational ripple-carry balanced-ternary adder, sum = a + b + cin.
module ternary_adder import ternary_pkg::*; #(parameter int WIDTH = 3) (
  input  trit_t [WIDTH-1:0] a,
  input  trit_t [WIDTH-1:0] b,
  input  trit_t             cin,
  output trit_t [WIDTH-1:0] sum,
  output trit_t             cout
);
  int s, t;
  trit_t c;
  always_comb begin
    s = 0;
    t = 0;
    c = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = trit_val(a[i]) + trit_val(b[i]) + trit_val(c);
      t = s > 1 ? 1 : s < -1 ? -1 : 0;
      sum[i] = trit_of(s - 3 * t);
      c = trit_of(t);
    end
    cout = c;
  end
endmodule

// File: rtl/ternary_serial_subtractor.sv
// ternary_serial_subtractor: digit-serial balanced-ternary a - b - bin, CHUNK trits per clock.
// Define TERNARY_SUB_SAT_EN to clamp diff to the range extreme when the carry trit overflows.
module ternary_serial_subtractor import ternary_pkg::*; #(
  parameter int WIDTH = 27,
  parameter int CHUNK = 3
) (
  input logic clk,
  input logic rst_n,
  ternary_serial_subtractor_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("WIDTH must be a multiple of CHUNK");
  end
  tsub_state_e state;
  trit_t [WIDTH-1:0] ra, rb, res, dv, nb;
  trit_t [CHUNK-1:0] csum;
  trit_t carry, cout, bout_r, bo_eff;
  logic [CW-1:0] cnt;
  logic in_ready_r, out_valid_r, neg_ms;
  ternary_adder #(.WIDTH(CHUNK)) u_add (
    .a(ra[CHUNK-1:0]), .b(rb[CHUNK-1:0]), .cin(carry), .sum(csum), .cout(cout)
  );
  always_comb begin
    nb = '0;
    for (int i = 0; i < WIDTH; i++) nb[i] = trit_neg(bus.b[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
      ra <= '0;
      rb <= '0;
      res <= '0;
      carry <= T_ZERO;
      bout_r <= T_ZERO;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          ra <= bus.a;
          rb <= nb;
          carry <= trit_neg(bus.bin);
          cnt <= '0;
          in_ready_r <= 1'b0;
          state <= BUSY;
        end
        BUSY: begin
          // sum trits enter at the top so the LS chunk ends up at the bottom after N shifts
          res <= (2*WIDTH)'({csum, res} >> (2*CHUNK));
          ra <= ra >> (2*CHUNK);
          rb <= rb >> (2*CHUNK);
          carry <= cout;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            bout_r <= cout;
            out_valid_r <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TERNARY_SUB_SAT_EN
  assign dv = !out_valid_r ? res : bout_r == T_POS ? {WIDTH{T_POS}} : bout_r == T_NEG ? {WIDTH{T_NEG}} : res;
  assign bo_eff = T_ZERO;
`else
  assign dv = res;
  assign bo_eff = bout_r;
`endif
  always_comb begin
    neg_ms = 1'b0;
    for (int i = 0; i < WIDTH; i++) neg_ms = dv[i] != T_ZERO ? dv[i] == T_NEG : neg_ms;
  end
  assign bus.in_ready = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.diff = dv;
  assign bus.bout = bout_r;
  assign bus.is_zero = out_valid_r && bo_eff == T_ZERO && dv == '0;
  assign bus.is_neg = out_valid_r && (bo_eff == T_NEG || (bo_eff == T_ZERO && neg_ms));
endmodule

// File: doc/ternary_serial_subtractor.md
Name: ternary_serial_subtractor

Overview:
- Digit-serial balanced-ternary subtractor computing diff = a − b − bin over WIDTH trits, CHUNK trits per clock, least-significant chunk first.
- It is the inverse-direction companion to the combinational adder path. It negates b trit-wise, negates bin, and feeds a CHUNK-wide adder with a registered inter-chunk carry.
- It sits beside the ALU for area-constrained multi-cycle subtract/compare, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 27, operand width in trits.
- CHUNK, 3, trits processed per cycle. WIDTH % CHUNK must be 0; any other value is an elaboration $error.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- a  input  trit_t[WIDTH]  minuend
- b  input  trit_t[WIDTH]  subtrahend
- bin  input  trit_t  borrow-in trit
- out_valid  output  1  result held
- out_ready  input  1  consumer accepts result
- diff  output  trit_t[WIDTH]  result trits
- bout  output  trit_t  final carry trit (overflow trit)
- is_zero  output  1  full result (bout:diff) equals 0
- is_neg  output  1  full result is negative

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state = IDLE; in_ready = 1; out_valid = 0; diff = all T_ZERO; bout = T_ZERO; is_zero = 0; is_neg = 0. Internal operand, carry and counter registers are cleared.
- State machine: IDLE → BUSY → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a rising edge, latch a into the shift register and neg(b) into the shift register, where neg maps POS↔NEG and ZERO→ZERO.
  - Set carry = neg(bin) and cnt = 0, then go to BUSY.
- BUSY:
  - in_ready = 0 and out_valid = 0.
  - Each edge, add the low CHUNK trits of the a and neg(b) registers plus carry.
  - Shift the CHUNK sum trits into the top of the result register, shift the operand registers right by CHUNK, register the chunk carry-out, and increment cnt.
  - When cnt reaches WIDTH/CHUNK−1, that edge performs the last chunk and moves to DONE.
  - Latency: out_valid rises exactly WIDTH/CHUNK cycles after the accepting edge (9 cycles at defaults).
- DONE:
  - out_valid = 1; diff and bout are held stable.
  - On out_valid && out_ready, go to IDLE. in_ready returns to 1 the following cycle; there is no same-cycle re-accept.
- Backpressure: DONE is held indefinitely while out_ready = 0. Inputs are ignored whenever state ≠ IDLE.
- Flags (combinational from registered result, forced 0 when out_valid = 0):
  - is_zero = 1 when bout and all diff trits are T_ZERO.
  - is_neg = 1 when bout = T_NEG; or when bout = T_ZERO and the most-significant nonzero diff trit is T_NEG.
- diff/bout outside DONE: undefined for the consumer (partial contents). The bench checks them only with out_valid.
- bout ≠ T_ZERO means the difference lies outside the WIDTH-trit range. The exact value is bout·3^WIDTH + diff.
- Reset asserted mid-BUSY or mid-DONE: immediate return to reset values; the in-flight operation is discarded.

Optional Feature:
- Macro: TERNARY_SUB_SAT_EN.
- Defined: in DONE, when bout = T_POS, diff reads all T_POS (maximum); when bout = T_NEG, diff reads all T_NEG (minimum). bout still reports the raw carry trit, and flags are computed from the saturated value with bout ignored.
- Undefined: diff is the wrap-around result as above.

Decomposition:
- ternary_pkg holds:
  - trit_t and constants T_NEG, T_ZERO, T_POS;
  - a trit_neg function;
  - the tsub_state_e enum {IDLE, BUSY, DONE}.
- Sub-module: instantiate the existing ternary_adder with WIDTH = CHUNK as the per-chunk datapath. No new sub-module is written.

Test Plan:
- WIDTH=9, CHUNK=3, a=5, b=7, bin=0, out_ready=1 → out_valid exactly 3 cycles after accept; diff=−2, bout=0, is_neg=1, is_zero=0.
- a=123, b=123, bin=0 → diff=0, bout=0, is_zero=1, is_neg=0.
- a=0, b=0, bin=T_POS → diff=−1, is_neg=1.
- Overflow, a=9841, b=−9841:
  - without macro → bout=T_POS, diff=−1, is_neg=0;
  - with TERNARY_SUB_SAT_EN → diff=9841 (all T_POS), bout=T_POS.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands → diff stable and in_ready=0 throughout; the second operation is accepted only after the release and return to IDLE.
- Assert rst_n=0 at BUSY cycle 2 → outputs immediately at reset values; after release, in_ready=1 and a fresh operation gives the correct result.
